ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_arb_pkg.sv | 12 +
 rtl/rr_arb2.sv | 33 +++
 rtl/ram_port_arbiter.sv | 129 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM port arbiter.
package ram_arb_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_M0   = 2'd1,
        RESP_M1   = 2'd2
    } resp_owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational in the request
// cycle; last_grant remembers which master won most recently (1 = m1).
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_grant;

    // Pick the single requester, or on a tie the master not granted last.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (req == 2'b11) begin
                gnt = last_grant ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // Remember the winner; reset points at m1 so m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (gnt != 2'b00) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port, write-first RAM between the core LSU (m0) and the
// accelerator (m1). Every grant yields exactly one response a cycle later;
// accesses outside the window or misaligned are answered with err and never
// reach the RAM.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req_i,
    input  logic [31:0]           m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_be_i,
    input  logic [31:0]           m0_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic                  m0_err_o,
    output logic [31:0]           m0_rdata_o,
    input  logic                  m1_req_i,
    input  logic [31:0]           m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_be_i,
    input  logic [31:0]           m1_wdata_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic                  m1_err_o,
    output logic [31:0]           m1_rdata_o,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    // Window size in bytes, held in 33 bits so the top-of-range compare never wraps.
    localparam logic [32:0] WINDOW_BYTES = 33'(WORD_BYTES) << ADDR_WIDTH;

    logic [1:0]  gnt;
    logic        granted;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_wdata;
    logic [32:0] offset;
    logic        invalid;
    logic        access_ok;

    resp_owner_e resp_q, resp_d;
    logic        err_q;
    logic        read_q;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({m1_req_i, m0_req_i}),
        .gnt (gnt)
    );

    assign m0_gnt_o = gnt[0];
    assign m1_gnt_o = gnt[1];
    assign granted  = gnt[0] | gnt[1];

    // Route the winner's request and classify it against the RAM window.
    always_comb begin
        sel_addr  = gnt[1] ? m1_addr_i  : m0_addr_i;
        sel_we    = gnt[1] ? m1_we_i    : m0_we_i;
        sel_be    = gnt[1] ? m1_be_i    : m0_be_i;
        sel_wdata = gnt[1] ? m1_wdata_i : m0_wdata_i;
        offset    = {1'b0, sel_addr} - {1'b0, BASE_ADDR};
        invalid   = (sel_addr[1:0] != 2'b00)
                 || ({1'b0, sel_addr} < {1'b0, BASE_ADDR})
                 || (offset >= WINDOW_BYTES);
        access_ok = granted && !invalid;
    end

    // Drive the RAM port only for a granted, valid access; park it at zero otherwise.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_addr_o  = '0;
        ram_wdata_o = 32'h0;
        if (access_ok) begin
            ram_en_o    = 1'b1;
            ram_we_o    = sel_we;
            ram_be_o    = sel_be;
            ram_addr_o  = offset[ADDR_WIDTH+1:2];
            ram_wdata_o = sel_wdata;
        end
    end

    // Next response owner is this cycle's winner, or nobody.
    always_comb begin
        resp_d = RESP_NONE;
        if (gnt[0]) begin
            resp_d = RESP_M0;
        end else if (gnt[1]) begin
            resp_d = RESP_M1;
        end
    end

    // Response state register with the error and read-data flags captured alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_q <= RESP_NONE;
            err_q  <= 1'b0;
            read_q <= 1'b0;
        end else begin
            resp_q <= resp_d;
            err_q  <= granted && invalid;
            read_q <= access_ok && !sel_we;
        end
    end

    // Steer the response; reset suppresses any response still in flight.
    always_comb begin
        m0_rvalid_o = !rst && (resp_q == RESP_M0);
        m1_rvalid_o = !rst && (resp_q == RESP_M1);
        m0_err_o    = m0_rvalid_o && err_q;
        m1_err_o    = m1_rvalid_o && err_q;
        m0_rdata_o  = (m0_rvalid_o && read_q) ? ram_rdata_i : 32'h0;
        m1_rdata_o  = (m1_rvalid_o && read_q) ? ram_rdata_i : 32'h0;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios followed by random traffic,
// checked each cycle against a transaction-level model of the arbiter and RAM.
module tb_ram_port_arbiter;

    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic [31:0] addr  [2];
    logic        we    [2];
    logic [3:0]  be    [2];
    logic [31:0] wdata [2];
    logic        gnt   [2];
    logic        rvalid[2];
    logic        err   [2];
    logic [31:0] rdata [2];

    logic          ram_en, ram_we;
    logic [3:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;

    logic [31:0] ram_mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    int checks = 0;
    int errors = 0;

    // Model state: last winner and the one response owed next cycle.
    int          exp_last;
    bit          pend_v;
    int          pend_m;
    bit          pend_err;
    logic [31:0] pend_data;

    // Observations saved from the most recent step for scenario-level checks.
    logic        obs_rvalid[2];
    logic        obs_err   [2];
    logic [31:0] obs_rdata [2];

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .m0_req_i    (req[0]),
        .m0_addr_i   (addr[0]),
        .m0_we_i     (we[0]),
        .m0_be_i     (be[0]),
        .m0_wdata_i  (wdata[0]),
        .m0_gnt_o    (gnt[0]),
        .m0_rvalid_o (rvalid[0]),
        .m0_err_o    (err[0]),
        .m0_rdata_o  (rdata[0]),
        .m1_req_i    (req[1]),
        .m1_addr_i   (addr[1]),
        .m1_we_i     (we[1]),
        .m1_be_i     (be[1]),
        .m1_wdata_i  (wdata[1]),
        .m1_gnt_o    (gnt[1]),
        .m1_rvalid_o (rvalid[1]),
        .m1_err_o    (err[1]),
        .m1_rdata_o  (rdata[1]),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_be_o    (ram_be),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    // Write-first single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            logic [31:0] word;
            word = ram_mem[ram_addr];
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) word[8*b +: 8] = ram_wdata[8*b +: 8];
                ram_mem[ram_addr] <= word;
            end
            ram_rdata <= word;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, want);
        end
    endtask

    task automatic drive(input int m, input bit wr, input logic [31:0] a,
                         input logic [3:0] bytes, input logic [31:0] d);
        req[m] = 1'b1; we[m] = wr; addr[m] = a; be[m] = bytes; wdata[m] = d;
    endtask

    task automatic idle();
        for (int m = 0; m < 2; m++) begin
            req[m] = 1'b0; we[m] = 1'b0; addr[m] = 32'h0; be[m] = 4'h0; wdata[m] = 32'h0;
        end
    endtask

    // One clock cycle: check everything mid-cycle, advance the model, move on.
    task automatic step();
        int          w;
        logic [63:0] a64;
        bit          inv;
        int          idx;
        logic [31:0] word;
        @(negedge clk);
        w = -1;
        if (!rst) begin
            if (req[0] && req[1]) w = (exp_last == 1) ? 0 : 1;
            else if (req[0])      w = 0;
            else if (req[1])      w = 1;
        end
        inv = 1'b0;
        idx = 0;
        if (w >= 0) begin
            a64 = {32'h0, addr[w]};
            inv = (a64[1:0] != 2'b00) || (a64 >= 64'(4 * DEPTH));
            idx = int'(a64 >> 2) % DEPTH;
        end
        chk("m0_gnt", 32'(gnt[0]), 32'(w == 0));
        chk("m1_gnt", 32'(gnt[1]), 32'(w == 1));
        if (w >= 0 && !inv) begin
            chk("ram_en",    32'(ram_en),    32'h1);
            chk("ram_we",    32'(ram_we),    32'(we[w]));
            chk("ram_be",    32'(ram_be),    32'(be[w]));
            chk("ram_addr",  32'(ram_addr),  32'(idx));
            chk("ram_wdata", ram_wdata,      wdata[w]);
        end else begin
            chk("ram_en_idle",    32'(ram_en),   32'h0);
            chk("ram_we_idle",    32'(ram_we),   32'h0);
            chk("ram_be_idle",    32'(ram_be),   32'h0);
            chk("ram_addr_idle",  32'(ram_addr), 32'h0);
            chk("ram_wdata_idle", ram_wdata,     32'h0);
        end
        for (int m = 0; m < 2; m++) begin
            bit mine;
            mine = !rst && pend_v && (pend_m == m);
            chk(m == 0 ? "m0_rvalid" : "m1_rvalid", 32'(rvalid[m]), 32'(mine));
            chk(m == 0 ? "m0_err"    : "m1_err",    32'(err[m]),    32'(mine && pend_err));
            chk(m == 0 ? "m0_rdata"  : "m1_rdata",  rdata[m],       mine ? pend_data : 32'h0);
            obs_rvalid[m] = rvalid[m];
            obs_err[m]    = err[m];
            obs_rdata[m]  = rdata[m];
        end
        if (rst) begin
            exp_last = 1;
            pend_v   = 1'b0;
        end else if (w >= 0) begin
            pend_v   = 1'b1;
            pend_m   = w;
            pend_err = inv;
            pend_data = 32'h0;
            if (!inv) begin
                if (we[w]) begin
                    word = ref_mem[idx];
                    for (int b = 0; b < 4; b++)
                        if (be[w][b]) word[8*b +: 8] = wdata[w][8*b +: 8];
                    ref_mem[idx] = word;
                end else begin
                    pend_data = ref_mem[idx];
                end
            end
            exp_last = w;
        end else begin
            pend_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        ram_rdata = 32'h0;
        exp_last  = 1;
        pend_v    = 1'b0;
        pend_m    = 0;
        pend_err  = 1'b0;
        pend_data = 32'h0;
        rst = 1'b1;
        idle();
        @(posedge clk); #1;
        // Requests under reset must not be granted.
        drive(0, 1'b0, 32'h10, 4'hF, 32'h0);
        drive(1, 1'b0, 32'h14, 4'hF, 32'h0);
        step();
        idle();
        step();
        rst = 1'b0;

        // m0 write then read of 0x10.
        drive(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        step();
        idle();
        drive(0, 1'b0, 32'h10, 4'hF, 32'h0);
        step();
        idle();
        step();
        chk("s_wr_rd_rvalid", 32'(obs_rvalid[0]), 32'h1);
        chk("s_wr_rd_rdata",  obs_rdata[0],       32'hDEADBEEF);
        chk("s_wr_rd_err",    32'(obs_err[0]),    32'h0);

        // Both masters requesting from reset alternate m0, m1, m0, m1.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b0, 32'h10, 4'hF, 32'h0);
            drive(1, 1'b0, 32'h14, 4'hF, 32'h0);
            #0;
            chk("s_tie_m0_turn", 32'(gnt[0]), 32'((k % 2) == 0));
            step();
        end
        idle();
        step();

        // m1 out-of-range and misaligned reads get err without touching the RAM.
        drive(1, 1'b0, 32'h4000, 4'hF, 32'h0);
        step();
        idle();
        drive(1, 1'b0, 32'h2, 4'hF, 32'h0);
        step();
        chk("s_oor_err", 32'(obs_err[1]), 32'h1);
        idle();
        step();
        chk("s_misal_err",   32'(obs_err[1]), 32'h1);
        chk("s_misal_rdata", obs_rdata[1],    32'h0);

        // Byte-lane merge.
        drive(0, 1'b1, 32'h20, 4'hF, 32'h11223344);
        step();
        drive(0, 1'b1, 32'h20, 4'b0010, 32'h0000AB00);
        step();
        drive(0, 1'b0, 32'h20, 4'hF, 32'h0);
        step();
        idle();
        step();
        chk("s_be_merge", obs_rdata[0], 32'h1122AB44);

        // Reset right after a grant drops its response.
        drive(0, 1'b0, 32'h10, 4'hF, 32'h0);
        step();
        idle();
        rst = 1'b1;
        step();
        chk("s_rst_drop", 32'(obs_rvalid[0]), 32'h0);
        rst = 1'b0;
        step();
        step();

        // Streaming reads, one per cycle.
        ref_mem[1] = 32'hA5A5_0001; ram_mem[1] = 32'hA5A5_0001;
        ref_mem[2] = 32'hA5A5_0002; ram_mem[2] = 32'hA5A5_0002;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b0, 32'(4 * k), 4'hF, 32'h0);
            step();
        end
        idle();
        step();
        chk("s_stream_last", obs_rdata[0], 32'hA5A5_0002);

        // Random two-master traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            idle();
            rst = ($urandom_range(0, 99) < 3);
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 99) < 65) begin
                    int          sel;
                    logic [31:0] a;
                    sel = $urandom_range(0, 9);
                    if (sel < 8)       a = 32'($urandom_range(0, 15)) << 2;
                    else if (sel == 8) a = (($urandom_range(0, 1) == 0) ? 32'h3FFC : 32'h4000);
                    else               a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
                    drive(m, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
                end
            end
            step();
        end
        rst = 1'b0;
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
